// File: rtl/asi_spram.sv
// asi_spram: single-port synchronous RAM behind the AXI slave RAM port, with
// byte-strobed writes, SLV_WS-cycle read latency and out-of-range detection.
// Optional per-byte even parity is enabled by defining SPRAM_PARITY_EN.
module asi_spram #(
  parameter  int AXI_DW    = 128,
  parameter  int AXI_AW    = 40,
  parameter  int RAM_WORDS = 1024,
  parameter  int SLV_WS    = 1,
  localparam int AXI_BYTES = AXI_DW / 8
) (
  input  logic                 RAM_CLK,
  input  logic                 RAM_RESETn,
  input  logic                 RAM_CEN,
  input  logic [AXI_BYTES-1:0] RAM_WEN,
  input  logic [AXI_AW-1:0]    RAM_A,
  input  logic [AXI_DW-1:0]    RAM_D,
  output logic [AXI_DW-1:0]    RAM_Q,
  output logic                 RAM_OOR,
  output logic                 RAM_PERR,
  input  logic                 PERR_INJ
);

  localparam int BYTE_SHIFT = $clog2(AXI_BYTES);
  localparam int IDX_W      = $clog2(RAM_WORDS);
  localparam int PIPE_N     = (SLV_WS > 1) ? SLV_WS - 1 : 1;

  // Access decode
  logic [AXI_AW-1:0] word_full;
  logic [IDX_W-1:0]  idx;
  logic              oor;
  logic              acc;
  logic              wr;
  logic              rd;

  assign word_full = RAM_A >> BYTE_SHIFT;
  assign idx       = word_full[IDX_W-1:0];
  assign oor       = (word_full >= AXI_AW'(RAM_WORDS));
  assign acc       = !RAM_CEN;
  assign wr        = acc && !(&RAM_WEN);
  assign rd        = acc && (&RAM_WEN);

  // Storage array
  logic [AXI_DW-1:0] mem_q [RAM_WORDS];
  logic [AXI_DW-1:0] rd_word;

  // NOTE: the array deliberately has no reset branch; it maps onto RAM macros
  // and its contents must survive RAM_RESETn.
  always_ff @(posedge RAM_CLK) begin
    if (wr && !oor) begin
      for (int b = 0; b < AXI_BYTES; b++) begin
        if (!RAM_WEN[b]) begin
          mem_q[idx][8*b +: 8] <= RAM_D[8*b +: 8];
        end
      end
    end
  end

  assign rd_word = mem_q[idx];

  // Read capture: out-of-range reads return zero and never flag parity
  logic              cap_valid;
  logic [AXI_DW-1:0] cap_data;
  logic              cap_perr;

  assign cap_valid = rd;
  assign cap_data  = oor ? '0 : rd_word;

`ifdef SPRAM_PARITY_EN
  logic [AXI_BYTES-1:0] par_q [RAM_WORDS];

  always_ff @(posedge RAM_CLK) begin
    if (wr && !oor) begin
      for (int b = 0; b < AXI_BYTES; b++) begin
        if (!RAM_WEN[b]) begin
          par_q[idx][b] <= (^RAM_D[8*b +: 8]) ^ PERR_INJ;
        end
      end
    end
  end

  // NOTE: always_comb gives every output a default first so no latch is inferred.
  always_comb begin
    cap_perr = 1'b0;
    if (!oor) begin
      for (int b = 0; b < AXI_BYTES; b++) begin
        if ((^rd_word[8*b +: 8]) != par_q[idx][b]) begin
          cap_perr = 1'b1;
        end
      end
    end
  end
`else
  logic unused_perr_inj;

  assign cap_perr        = 1'b0;
  assign unused_perr_inj = PERR_INJ;
`endif

  // Read pipeline: the output register is the final stage, so SLV_WS-1 extra
  // stages sit between capture and RAM_Q.
  logic              ex_valid;
  logic [AXI_DW-1:0] ex_data;
  logic              ex_perr;

  if (SLV_WS > 1) begin : g_pipe
    logic [PIPE_N-1:0] vld_q, vld_d;
    logic [PIPE_N-1:0] pe_q,  pe_d;
    logic [AXI_DW-1:0] dat_q [PIPE_N];
    logic [AXI_DW-1:0] dat_d [PIPE_N];

    always_comb begin
      vld_d[0] = cap_valid;
      pe_d[0]  = cap_perr;
      dat_d[0] = cap_data;
      for (int i = 1; i < PIPE_N; i++) begin
        vld_d[i] = vld_q[i-1];
        pe_d[i]  = pe_q[i-1];
        dat_d[i] = dat_q[i-1];
      end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge RAM_CLK or negedge RAM_RESETn) begin
      if (!RAM_RESETn) begin
        vld_q <= '0;
        pe_q  <= '0;
        dat_q <= '{default: '0};
      end else begin
        vld_q <= vld_d;
        pe_q  <= pe_d;
        dat_q <= dat_d;
      end
    end

    assign ex_valid = vld_q[PIPE_N-1];
    assign ex_perr  = pe_q[PIPE_N-1];
    assign ex_data  = dat_q[PIPE_N-1];
  end else begin : g_direct
    assign ex_valid = cap_valid;
    assign ex_perr  = cap_perr;
    assign ex_data  = cap_data;
  end

  // Output registers: RAM_Q holds unless a valid stage exits
  logic [AXI_DW-1:0] q_q, q_d;
  logic              perr_q, perr_d;
  logic              oor_q, oor_d;

  assign q_d    = ex_valid ? ex_data : q_q;
  assign perr_d = ex_valid && ex_perr;
  assign oor_d  = acc && oor;

  always_ff @(posedge RAM_CLK or negedge RAM_RESETn) begin
    if (!RAM_RESETn) begin
      q_q    <= '0;
      perr_q <= 1'b0;
      oor_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      perr_q <= perr_d;
      oor_q  <= oor_d;
    end
  end

  assign RAM_Q    = q_q;
  assign RAM_OOR  = oor_q;
  assign RAM_PERR = perr_q;

endmodule
